vape_region_ctrl: RTL and testbench

Configuration and sequencing controller for the VAPE output-protection monitor. Holds the ER/OR bound registers in a small memory-mapped window, locks them once software arms an execution, and tracks the protected run from ER entry to legal exit. Samples the monitor's exec flag and records completion or fault in a status register. Sits beside the MSP430 core; its bound outputs feed the monitor directly.

---
 rtl/vape_region_ctrl_pkg.sv | 26 ++
 rtl/vape_region_regfile.sv | 72 +++++++
 rtl/vape_region_ctrl.sv | 143 ++++++++++++++
 tb/tb_vape_region_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vape_region_ctrl_pkg.sv
// Shared constants for the VAPE region controller: state codes, register map, CTRL/STATUS bits.
// Latency: none (definitions only).
// Backpressure: none.
package vape_region_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CONFIG  = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [15:0] VAPE_META_BASE = 16'h0140;
    localparam int          NUM_REGS       = 5;

    localparam logic [2:0] OFF_ER_MIN = 3'd0;
    localparam logic [2:0] OFF_ER_MAX = 3'd1;
    localparam logic [2:0] OFF_OR_MIN = 3'd2;
    localparam logic [2:0] OFF_OR_MAX = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int CTRL_ARM_BIT = 0;
    localparam int CTRL_CLR_BIT = 1;

endpackage

// File: rtl/vape_region_regfile.sv
// Bound registers with lock-gated write decode and a registered read port.
// Latency: writes land on the strobe edge; data_dout valid the cycle after data_rd.
// Backpressure: none, single-cycle bus access always accepted or silently dropped.
module vape_region_regfile
    import vape_region_ctrl_pkg::*;
#(
    parameter logic [15:0] META_BASE = VAPE_META_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_addr,
    input  logic        data_wr,
    input  logic        data_rd,
    input  logic [15:0] data_din,
    input  logic        locked,
    input  logic [15:0] status,
    output logic [15:0] data_dout,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic [15:0] or_min,
    output logic [15:0] or_max,
    output logic        ctrl_wr,
    output logic        bound_wr
);

    logic [14:0] word_off;
    logic        in_win;
    logic [15:0] rd_mux;

    // Offset relative to the window; out-of-window addresses wrap to large values.
    assign word_off = data_addr[15:1] - META_BASE[15:1];
    assign in_win   = (word_off < 15'(NUM_REGS));
    assign ctrl_wr  = data_wr && in_win && (word_off[2:0] == OFF_CTRL);
    assign bound_wr = data_wr && in_win && (word_off[2:0] != OFF_CTRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            er_min <= '0;
            er_max <= '0;
            or_min <= '0;
            or_max <= '0;
        end else if (bound_wr && !locked) begin
            case (word_off[2:0])
                OFF_ER_MIN: er_min <= data_din;
                OFF_ER_MAX: er_max <= data_din;
                OFF_OR_MIN: or_min <= data_din;
                OFF_OR_MAX: or_max <= data_din;
                default:    ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word_off[2:0])
            OFF_ER_MIN: rd_mux = er_min;
            OFF_ER_MAX: rd_mux = er_max;
            OFF_OR_MIN: rd_mux = or_min;
            OFF_OR_MAX: rd_mux = or_max;
            OFF_CTRL:   rd_mux = status;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_dout <= '0;
        else if (data_rd && in_win)
            data_dout <= rd_mux;
    end

endmodule

// File: rtl/vape_region_ctrl.sv
// VAPE region controller: bound config/lock, ER run tracking, sticky done/fault status (irq under VAPE_CTRL_IRQ_EN).
// Latency: state, done/fault and irq update on the edge that samples the trigger; read data one cycle after data_rd.
// Backpressure: none; bound writes while locked are dropped (and fault the run when armed).
module vape_region_ctrl
    import vape_region_ctrl_pkg::*;
#(
    parameter logic [15:0] META_BASE     = VAPE_META_BASE,
    parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic [15:0] data_addr,
    input  logic        data_wr,
    input  logic        data_rd,
    input  logic [15:0] data_din,
    output logic [15:0] data_dout,
    input  logic        exec_in,
    output logic [15:0] ER_min,
    output logic [15:0] ER_max,
    output logic [15:0] OR_min,
    output logic [15:0] OR_max,
    output logic        locked,
    output logic        done,
    output logic        fault,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [15:0] prev_pc;
    logic        exec_q;
    logic        done_q, fault_q;
    logic        ctrl_wr, bound_wr;
    logic        arm_req, clr_req;
    logic        bounds_ok, pc_in_er, exec_fell;
    logic [15:0] status;

    assign locked    = (state_q != ST_CONFIG);
    assign done      = done_q;
    assign fault     = fault_q;
    assign status    = {10'd0, locked, fault_q, done_q, state_q};

    // ARM together with CLR is treated as CLR only.
    assign clr_req   = ctrl_wr && data_din[CTRL_CLR_BIT];
    assign arm_req   = ctrl_wr && data_din[CTRL_ARM_BIT] && !data_din[CTRL_CLR_BIT];
    assign bounds_ok = (ER_min <= ER_max) && (OR_min < OR_max);
    assign pc_in_er  = (pc >= ER_min) && (pc <= ER_max);
    assign exec_fell = exec_q && !exec_in;

    vape_region_regfile #(
        .META_BASE (META_BASE)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_addr (data_addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .data_din  (data_din),
        .locked    (locked),
        .status    (status),
        .data_dout (data_dout),
        .er_min    (ER_min),
        .er_max    (ER_max),
        .or_min    (OR_min),
        .or_max    (OR_max),
        .ctrl_wr   (ctrl_wr),
        .bound_wr  (bound_wr)
    );

    always_comb begin
        state_d = state_q;
        if (pc == RESET_HANDLER) begin
            state_d = ST_CONFIG;
        end else if (clr_req) begin
            state_d = ST_CONFIG;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    if (arm_req)
                        state_d = bounds_ok ? ST_ARMED : ST_FAULT;
                end
                ST_ARMED: begin
                    // Landing inside the ER anywhere but its entry point skips the prologue.
                    if (bound_wr)
                        state_d = ST_FAULT;
                    else if (pc == ER_min)
                        state_d = ST_RUNNING;
                    else if ((pc > ER_min) && (pc <= ER_max))
                        state_d = ST_FAULT;
                end
                ST_RUNNING: begin
                    if (exec_fell)
                        state_d = ST_FAULT;
                    else if (!pc_in_er)
                        state_d = ((prev_pc == ER_max) && exec_in) ? ST_DONE : ST_FAULT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CONFIG;
            prev_pc <= '0;
            exec_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_pc <= pc;
            exec_q  <= exec_in;
            if (clr_req) begin
                done_q  <= 1'b0;
                fault_q <= 1'b0;
            end else begin
                if ((state_d == ST_DONE) && (state_q != ST_DONE))
                    done_q <= 1'b1;
                if ((state_d == ST_FAULT) && (state_q != ST_FAULT))
                    fault_q <= 1'b1;
            end
        end
    end

`ifdef VAPE_CTRL_IRQ_EN
    logic irq_q;
    logic entering_end;

    assign entering_end = ((state_d == ST_DONE) || (state_d == ST_FAULT)) && (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_q <= 1'b0;
        else
            irq_q <= entering_end;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vape_region_ctrl.sv
// Directed bench for vape_region_ctrl: bus config, armed runs, fault paths, resets.
// Inputs driven 1ns after posedge; outputs checked at the same point.
module tb_vape_region_ctrl;

    localparam logic [15:0] META_BASE = 16'h0140;
    localparam int OFF_ER_MIN = 0, OFF_ER_MAX = 1, OFF_OR_MIN = 2, OFF_OR_MAX = 3, OFF_CTRL = 4;
`ifdef VAPE_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        data_wr;
    logic        data_rd;
    logic [15:0] data_din;
    logic [15:0] data_dout;
    logic        exec_in;
    logic [15:0] ER_min, ER_max, OR_min, OR_max;
    logic        locked, done, fault, irq;

    int n_vec = 0;
    int n_err = 0;

    vape_region_ctrl #(.META_BASE(META_BASE), .RESET_HANDLER(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .data_addr (data_addr),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .data_din  (data_din),
        .data_dout (data_dout),
        .exec_in   (exec_in),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .OR_min    (OR_min),
        .OR_max    (OR_max),
        .locked    (locked),
        .done      (done),
        .fault     (fault),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int off, input logic [15:0] v);
        data_addr = META_BASE + 16'(2 * off);
        data_din  = v;
        data_wr   = 1'b1;
        tick();
        data_wr   = 1'b0;
    endtask

    task automatic bus_rd(input int off);
        data_addr = META_BASE + 16'(2 * off);
        data_rd   = 1'b1;
        tick();
        data_rd   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = 16'h4000; exec_in = 1'b1;
        data_addr = 16'h0; data_wr = 1'b0; data_rd = 1'b0; data_din = 16'h0;
        #12;
        n_vec++; if (data_dout !== 16'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0000", data_dout); end
        n_vec++; if ({ER_min, ER_max, OR_min, OR_max} !== 64'h0) begin n_err++; $display("FAIL reset_bounds: got %h want 0", {ER_min, ER_max, OR_min, OR_max}); end
        n_vec++; if ({locked, done, fault, irq} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {locked, done, fault, irq}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_config_arm();
        bus_wr(OFF_ER_MIN, 16'hE000);
        bus_wr(OFF_ER_MAX, 16'hE0FE);
        bus_wr(OFF_OR_MIN, 16'h0200);
        bus_wr(OFF_OR_MAX, 16'h021E);
        n_vec++; if ({ER_min, ER_max, OR_min, OR_max} !== 64'hE000_E0FE_0200_021E) begin n_err++; $display("FAIL cfg_bounds: got %h want E000E0FE0200021E", {ER_min, ER_max, OR_min, OR_max}); end
        bus_wr(OFF_CTRL, 16'h0001);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL arm_locked: got %b want 1", locked); end
        for (int a = 16'hE000; a <= 16'hE0FE; a += 2) begin
            pc = 16'(a);
            tick();
        end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL run_not_done: got %b want 0", done); end
        pc = 16'hC000;
        tick();
        n_vec++; if ({done, fault} !== 2'b10) begin n_err++; $display("FAIL run_done: got %b want 10", {done, fault}); end
        n_vec++; if (irq !== IRQ_ON) begin n_err++; $display("FAIL done_irq: got %b want %b", irq, IRQ_ON); end
        bus_rd(OFF_CTRL);
        n_vec++; if (data_dout !== 16'h002B) begin n_err++; $display("FAIL done_status: got %h want 002b", data_dout); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL done_irq_pulse: got %b want 0", irq); end
        bus_wr(OFF_CTRL, 16'h0002);
        n_vec++; if ({locked, done} !== 2'b00) begin n_err++; $display("FAIL clr_after_done: got %b want 00", {locked, done}); end
        pc = 16'h4000;
        tick();
    endtask

    task automatic test_write_while_armed();
        bus_wr(OFF_CTRL, 16'h0001);
        bus_wr(OFF_ER_MIN, 16'h1234);
        n_vec++; if (ER_min !== 16'hE000) begin n_err++; $display("FAIL armed_wr_dropped: got %h want e000", ER_min); end
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL armed_wr_fault: got %b want 1", fault); end
        bus_rd(OFF_CTRL);
        n_vec++; if (data_dout !== 16'h0034) begin n_err++; $display("FAIL armed_wr_status: got %h want 0034", data_dout); end
        bus_wr(OFF_CTRL, 16'h0003);
        n_vec++; if ({locked, fault} !== 2'b00) begin n_err++; $display("FAIL arm_clr_both: got %b want 00", {locked, fault}); end
    endtask

    task automatic test_invalid_bounds();
        bus_wr(OFF_OR_MIN, 16'h0300);
        bus_wr(OFF_OR_MAX, 16'h0200);
        bus_wr(OFF_CTRL, 16'h0001);
        n_vec++; if ({locked, fault} !== 2'b11) begin n_err++; $display("FAIL bad_bounds: got %b want 11", {locked, fault}); end
        bus_wr(OFF_CTRL, 16'h0002);
        bus_wr(OFF_OR_MIN, 16'h0200);
        bus_wr(OFF_OR_MAX, 16'h0200);
        bus_wr(OFF_CTRL, 16'h0001);
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL or_equal_fault: got %b want 1", fault); end
        bus_wr(OFF_CTRL, 16'h0002);
        bus_wr(OFF_OR_MAX, 16'h021E);
        n_vec++; if ({OR_min, OR_max} !== 32'h0200_021E) begin n_err++; $display("FAIL or_restore: got %h want 0200021e", {OR_min, OR_max}); end
    endtask

    task automatic test_illegal_exit();
        bus_wr(OFF_CTRL, 16'h0001);
        for (int a = 16'hE000; a <= 16'hE010; a += 2) begin
            pc = 16'(a);
            tick();
        end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL mid_run_fault: got %b want 0", fault); end
        pc = 16'hC000;
        tick();
        n_vec++; if ({done, fault} !== 2'b01) begin n_err++; $display("FAIL illegal_exit: got %b want 01", {done, fault}); end
        bus_wr(OFF_CTRL, 16'h0002);
        bus_rd(OFF_CTRL);
        n_vec++; if (data_dout !== 16'h0000) begin n_err++; $display("FAIL clr_status: got %h want 0000", data_dout); end
        pc = 16'h4000;
        bus_wr(OFF_CTRL, 16'h0001);
        pc = 16'hE004;
        tick();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL skip_entry: got %b want 1", fault); end
        pc = 16'h4000;
        bus_wr(OFF_CTRL, 16'h0002);
    endtask

    task automatic test_exec_drop();
        bus_wr(OFF_CTRL, 16'h0001);
        for (int a = 16'hE000; a <= 16'hE020; a += 2) begin
            pc = 16'(a);
            tick();
        end
        exec_in = 1'b0;
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL exec_pre: got %b want 0", fault); end
        tick();
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL exec_drop: got %b want 1", fault); end
        n_vec++; if (irq !== IRQ_ON) begin n_err++; $display("FAIL exec_irq: got %b want %b", irq, IRQ_ON); end
        tick();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL exec_irq_pulse: got %b want 0", irq); end
        exec_in = 1'b1;
        pc = 16'h4000;
        bus_wr(OFF_CTRL, 16'h0002);
    endtask

    task automatic test_reset_pc();
        bus_wr(OFF_CTRL, 16'h0001);
        pc = 16'hE000; tick();
        pc = 16'hE002; tick();
        pc = 16'h0000; tick();
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_pc_lock: got %b want 0", locked); end
        bus_rd(OFF_CTRL);
        n_vec++; if (data_dout !== 16'h0000) begin n_err++; $display("FAIL reset_pc_status: got %h want 0000", data_dout); end
        pc = 16'h4000;
        tick();
    endtask

    task automatic test_async_reset();
        bus_wr(OFF_CTRL, 16'h0001);
        bus_rd(OFF_ER_MIN);
        n_vec++; if (data_dout !== 16'hE000) begin n_err++; $display("FAIL rd_er_min: got %h want e000", data_dout); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({data_dout, ER_min, OR_max} !== 48'h0) begin n_err++; $display("FAIL async_regs: got %h want 0", {data_dout, ER_min, OR_max}); end
        n_vec++; if ({locked, done, fault} !== 3'b000) begin n_err++; $display("FAIL async_flags: got %b want 000", {locked, done, fault}); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_config_arm();
        test_write_while_armed();
        test_invalid_bounds();
        test_illegal_exit();
        test_exec_drop();
        test_reset_pc();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
